// File: rtl/aisys_bus_pkg.sv
// Shared read-bus widths, arbiter FSM state encoding and a small index helper.
// Imported by the read-bus arbiter and its round-robin grant sub-module.
package aisys_bus_pkg;

    localparam int ADDR_W = 28;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arbState_e;

    // Increment an index modulo n (wraps n-1 back to 0).
    function automatic int wrapInc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches the request vector starting at ptr
// and returns a one-hot grant, the winner's index and a valid flag.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] gntIdx,
    output logic             valid
);

    int   idx_s;
    logic found_s;

    // First requester at or after ptr (wrapping) wins.
    always_comb begin
        gnt     = '0;
        gntIdx  = '0;
        valid   = 1'b0;
        idx_s   = 0;
        found_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_s        = int'(ptr) + i;
            idx_s        = (idx_s >= N_REQ) ? (idx_s - N_REQ) : idx_s;
            found_s      = !valid && req[idx_s];
            gnt[idx_s]   = gnt[idx_s] | found_s;
            gntIdx       = found_s ? PTR_W'(idx_s) : gntIdx;
            valid        = valid | found_s;
        end
    end

endmodule

// File: rtl/rd_bus_arbiter.sv
// Read-bus arbiter: round-robin grants N_REQ requesters onto one read bus,
// one outstanding burst at a time, with an inter-beat watchdog and stray-beat flag.
module rd_bus_arbiter
    import aisys_bus_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              ReqArb_arvalid,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  ReqArb_araddr,
    input  logic [N_REQ-1:0][LEN_W-1:0]   ReqArb_arlen,
    input  logic [N_REQ-1:0][ID_W-1:0]    ReqArb_aruserid,
    input  logic [N_REQ-1:0]              ReqArb_aruserap,
    output logic [N_REQ-1:0]              ArbReq_arready,
    output logic [N_REQ-1:0]              ArbReq_rvalid,
    output logic [DATA_W-1:0]             ArbReq_rdata,
    output logic [ID_W-1:0]               ArbReq_rid,
    output logic                          ArbReq_rlast,
    output logic                          ArbBus_arvalid,
    output logic [ADDR_W-1:0]             ArbBus_araddr,
    output logic [LEN_W-1:0]              ArbBus_arlen,
    output logic [ID_W-1:0]               ArbBus_aruserid,
    output logic                          ArbBus_aruserap,
    input  logic                          BusArb_arready,
    input  logic                          BusArb_rvalid,
    input  logic                          BusArb_rlast,
    input  logic [ID_W-1:0]               BusArb_rid,
    input  logic [DATA_W-1:0]             BusArb_rdata,
    output logic                          ArbErr_timeout,
    output logic                          ArbErr_stray
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arbState_e          state_r, stateNext_s;
    logic [PTR_W-1:0]   ptr_r, ptrNext_s, gIdx_r, winIdx_s;
    logic [N_REQ-1:0]   winGnt_s, gntVec_r;
    logic               winValid_s, loadCap_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [LEN_W-1:0]   len_r;
    logic [ID_W-1:0]    id_r;
    logic               ap_r;
    logic [15:0]        wdog_r;
    logic               stray_r;
    logic               matched_s, timeout_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req    (ReqArb_arvalid),
        .ptr    (ptr_r),
        .gnt    (winGnt_s),
        .gntIdx (winIdx_s),
        .valid  (winValid_s)
    );

    assign matched_s = (state_r == ST_DATA) && BusArb_rvalid && (BusArb_rid == id_r);
    // Watchdog holds the idle count of completed DATA cycles; this cycle would reach TIMEOUT.
    assign timeout_s = (state_r == ST_DATA) && !matched_s && (wdog_r == 16'(TIMEOUT - 1));

    // Next-state, pointer advance and payload-capture decode.
    always_comb begin
        stateNext_s = state_r;
        ptrNext_s   = ptr_r;
        loadCap_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (winValid_s) begin
                    stateNext_s = ST_ADDR;
                    loadCap_s   = 1'b1;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (BusArb_arready) begin
                    stateNext_s = ST_DATA;
                end else begin
                    stateNext_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if ((matched_s && BusArb_rlast) || timeout_s) begin
                    stateNext_s = ST_IDLE;
                    ptrNext_s   = PTR_W'(wrapInc(int'(gIdx_r), N_REQ));
                end else begin
                    stateNext_s = ST_DATA;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer, captured payload, watchdog and stray flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ptr_r    <= '0;
            gIdx_r   <= '0;
            gntVec_r <= '0;
            addr_r   <= '0;
            len_r    <= '0;
            id_r     <= '0;
            ap_r     <= 1'b0;
            wdog_r   <= 16'd0;
            stray_r  <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            ptr_r   <= ptrNext_s;
            if (loadCap_s) begin
                gIdx_r   <= winIdx_s;
                gntVec_r <= winGnt_s;
                addr_r   <= ReqArb_araddr[winIdx_s];
                len_r    <= ReqArb_arlen[winIdx_s];
                id_r     <= ReqArb_aruserid[winIdx_s];
                ap_r     <= ReqArb_aruserap[winIdx_s];
            end
            // Zero outside DATA so entry always starts from a cleared count.
            if ((state_r == ST_DATA) && !matched_s) begin
                wdog_r <= wdog_r + 16'd1;
            end else begin
                wdog_r <= 16'd0;
            end
            stray_r <= BusArb_rvalid && !matched_s;
        end
    end

    assign ArbBus_arvalid  = (state_r == ST_ADDR);
    assign ArbBus_araddr   = addr_r;
    assign ArbBus_arlen    = len_r;
    assign ArbBus_aruserid = id_r;
    assign ArbBus_aruserap = ap_r;

    assign ArbReq_arready  = ((state_r == ST_ADDR) && BusArb_arready) ? gntVec_r : '0;
    assign ArbReq_rvalid   = matched_s ? gntVec_r : '0;
    assign ArbReq_rdata    = BusArb_rdata;
    assign ArbReq_rid      = BusArb_rid;
    assign ArbReq_rlast    = BusArb_rlast;

    assign ArbErr_timeout  = timeout_s;
    assign ArbErr_stray    = stray_r;

endmodule

// File: tb/tb_rd_bus_arbiter.sv
// Directed self-checking bench for rd_bus_arbiter (N_REQ=4, TIMEOUT=8).
module tb_rd_bus_arbiter;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           ReqArb_arvalid;
    logic [3:0][27:0]     ReqArb_araddr;
    logic [3:0][3:0]      ReqArb_arlen;
    logic [3:0][3:0]      ReqArb_aruserid;
    logic [3:0]           ReqArb_aruserap;
    logic [3:0]           ArbReq_arready;
    logic [3:0]           ArbReq_rvalid;
    logic [31:0]          ArbReq_rdata;
    logic [3:0]           ArbReq_rid;
    logic                 ArbReq_rlast;
    logic                 ArbBus_arvalid;
    logic [27:0]          ArbBus_araddr;
    logic [3:0]           ArbBus_arlen;
    logic [3:0]           ArbBus_aruserid;
    logic                 ArbBus_aruserap;
    logic                 BusArb_arready;
    logic                 BusArb_rvalid;
    logic                 BusArb_rlast;
    logic [3:0]           BusArb_rid;
    logic [31:0]          BusArb_rdata;
    logic                 ArbErr_timeout;
    logic                 ArbErr_stray;

    int nChecks = 0;
    int nErrors = 0;

    rd_bus_arbiter #(.N_REQ(4), .TIMEOUT(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ReqArb_arvalid  (ReqArb_arvalid),
        .ReqArb_araddr   (ReqArb_araddr),
        .ReqArb_arlen    (ReqArb_arlen),
        .ReqArb_aruserid (ReqArb_aruserid),
        .ReqArb_aruserap (ReqArb_aruserap),
        .ArbReq_arready  (ArbReq_arready),
        .ArbReq_rvalid   (ArbReq_rvalid),
        .ArbReq_rdata    (ArbReq_rdata),
        .ArbReq_rid      (ArbReq_rid),
        .ArbReq_rlast    (ArbReq_rlast),
        .ArbBus_arvalid  (ArbBus_arvalid),
        .ArbBus_araddr   (ArbBus_araddr),
        .ArbBus_arlen    (ArbBus_arlen),
        .ArbBus_aruserid (ArbBus_aruserid),
        .ArbBus_aruserap (ArbBus_aruserap),
        .BusArb_arready  (BusArb_arready),
        .BusArb_rvalid   (BusArb_rvalid),
        .BusArb_rlast    (BusArb_rlast),
        .BusArb_rid      (BusArb_rid),
        .BusArb_rdata    (BusArb_rdata),
        .ArbErr_timeout  (ArbErr_timeout),
        .ArbErr_stray    (ArbErr_stray)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setReq(input int i, input logic [27:0] a, input logic [3:0] l,
                          input logic [3:0] id, input logic ap);
        ReqArb_araddr[i]   = a;
        ReqArb_arlen[i]    = l;
        ReqArb_aruserid[i] = id;
        ReqArb_aruserap[i] = ap;
    endtask

    // Wait (bounded) for the address phase, check payload, handshake into DATA.
    task automatic addrPhase(input int g, input logic [27:0] a, input logic [3:0] l,
                             input logic [3:0] id, input logic ap);
        int n = 0;
        while (!ArbBus_arvalid && n < 20) begin
            tick();
            n++;
        end
        checkVal("ar_arvalid", {31'd0, ArbBus_arvalid}, 32'd1);
        checkVal("ar_araddr", {4'd0, ArbBus_araddr}, {4'd0, a});
        checkVal("ar_arlen", {28'd0, ArbBus_arlen}, {28'd0, l});
        checkVal("ar_id", {28'd0, ArbBus_aruserid}, {28'd0, id});
        checkVal("ar_ap", {31'd0, ArbBus_aruserap}, {31'd0, ap});
        BusArb_arready = 1'b1;
        #1;
        checkVal("arready_grant", {28'd0, ArbReq_arready}, 32'd1 << g);
        tick();
        BusArb_arready = 1'b0;
        #1;
        checkVal("data_no_arvalid", {31'd0, ArbBus_arvalid}, 32'd0);
    endtask

    task automatic beat(input int g, input logic [3:0] id, input logic last, input logic [31:0] d);
        BusArb_rvalid = 1'b1;
        BusArb_rid    = id;
        BusArb_rlast  = last;
        BusArb_rdata  = d;
        #1;
        checkVal("beat_rvalid", {28'd0, ArbReq_rvalid}, 32'd1 << g);
        checkVal("beat_rdata", ArbReq_rdata, d);
        tick();
        BusArb_rvalid = 1'b0;
        BusArb_rlast  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ReqArb_arvalid = 4'd0;
        ReqArb_araddr = '0;
        ReqArb_arlen = '0;
        ReqArb_aruserid = '0;
        ReqArb_aruserap = 4'd0;
        BusArb_arready = 1'b0;
        BusArb_rvalid = 1'b0;
        BusArb_rlast = 1'b0;
        BusArb_rid = 4'd0;
        BusArb_rdata = 32'd0;
        tick();
        checkVal("rst_arvalid", {31'd0, ArbBus_arvalid}, 32'd0);
        checkVal("rst_araddr", {4'd0, ArbBus_araddr}, 32'd0);
        checkVal("rst_arready", {28'd0, ArbReq_arready}, 32'd0);
        checkVal("rst_errs", {30'd0, ArbErr_timeout, ArbErr_stray}, 32'd0);
        rst_n = 1'b1;
        tick();

        // All four requesting continuously: grants 0,1,2,3,0 with an IDLE gap each.
        for (int i = 0; i < 4; i++) setReq(i, 28'(32'h10 * (i + 1)), 4'd0, 4'(i + 1), 1'b0);
        ReqArb_arvalid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            addrPhase(k % 4, 28'(32'h10 * ((k % 4) + 1)), 4'd0, 4'((k % 4) + 1), 1'b0);
            beat(k % 4, 4'((k % 4) + 1), 1'b1, 32'(32'hA000 + k));
            checkVal("rr_gap_idle", {31'd0, ArbBus_arvalid}, 32'd0);
        end
        ReqArb_arvalid = 4'd0;
        tick();

        // Req1 alone, 4 beats with id 9; drops arvalid once granted.
        setReq(1, 28'h0000100, 4'd3, 4'd9, 1'b1);
        ReqArb_arvalid = 4'b0010;
        #1;
        checkVal("req1_idle_first", {31'd0, ArbBus_arvalid}, 32'd0);
        tick();
        ReqArb_arvalid = 4'd0;
        addrPhase(1, 28'h0000100, 4'd3, 4'd9, 1'b1);
        for (int k = 0; k < 4; k++) beat(1, 4'd9, (k == 3), 32'(32'hB0 + k));
        checkVal("req1_idle_after", {31'd0, ArbBus_arvalid}, 32'd0);
        tick();
        checkVal("req1_no_regrant", {31'd0, ArbBus_arvalid}, 32'd0);

        // Bus stalls arready for 5 cycles: payload stable, arready pulses once.
        setReq(2, 28'hABCDEF0, 4'd1, 4'd5, 1'b0);
        ReqArb_arvalid = 4'b0100;
        tick();
        ReqArb_arvalid = 4'd0;
        for (int k = 0; k < 5; k++) begin
            checkVal("stall_arvalid", {31'd0, ArbBus_arvalid}, 32'd1);
            checkVal("stall_araddr", {4'd0, ArbBus_araddr}, 32'h0ABCDEF0);
            checkVal("stall_arready", {28'd0, ArbReq_arready}, 32'd0);
            tick();
        end
        addrPhase(2, 28'hABCDEF0, 4'd1, 4'd5, 1'b0);
        checkVal("stall_arready_once", {28'd0, ArbReq_arready}, 32'd0);
        beat(2, 4'd5, 1'b0, 32'h11);
        beat(2, 4'd5, 1'b1, 32'h22);

        // Mismatched rid while id 9 is granted: dropped, stray one cycle later.
        setReq(3, 28'h0000300, 4'd0, 4'd9, 1'b0);
        ReqArb_arvalid = 4'b1000;
        tick();
        ReqArb_arvalid = 4'd0;
        addrPhase(3, 28'h0000300, 4'd0, 4'd9, 1'b0);
        BusArb_rvalid = 1'b1;
        BusArb_rid = 4'd3;
        BusArb_rlast = 1'b1;
        #1;
        checkVal("stray_no_rvalid", {28'd0, ArbReq_rvalid}, 32'd0);
        checkVal("stray_not_yet", {31'd0, ArbErr_stray}, 32'd0);
        tick();
        BusArb_rvalid = 1'b0;
        BusArb_rlast = 1'b0;
        checkVal("stray_pulse", {31'd0, ArbErr_stray}, 32'd1);
        tick();
        checkVal("stray_cleared", {31'd0, ArbErr_stray}, 32'd0);
        beat(3, 4'd9, 1'b1, 32'h33);

        // Watchdog: no beats after address phase; req1 waits behind req0.
        setReq(0, 28'h0000400, 4'd2, 4'd4, 1'b0);
        setReq(1, 28'h0000500, 4'd2, 4'd6, 1'b1);
        ReqArb_arvalid = 4'b0011;
        tick();
        ReqArb_arvalid = 4'b0010;
        addrPhase(0, 28'h0000400, 4'd2, 4'd4, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            checkVal($sformatf("timeout_cyc%0d", k), {31'd0, ArbErr_timeout}, {31'd0, (k == 8)});
            tick();
        end
        checkVal("timeout_idle", {31'd0, ArbBus_arvalid}, 32'd0);
        checkVal("timeout_cleared", {31'd0, ArbErr_timeout}, 32'd0);
        tick();
        ReqArb_arvalid = 4'd0;
        addrPhase(1, 28'h0000500, 4'd2, 4'd6, 1'b1);

        // Reset mid-DATA with a live beat; late beat after release is stray; req0 first.
        BusArb_rvalid = 1'b1;
        BusArb_rid = 4'd6;
        BusArb_rdata = 32'h44;
        #1;
        checkVal("pre_rst_rvalid", {28'd0, ArbReq_rvalid}, 32'd2);
        rst_n = 1'b0;
        #1;
        checkVal("midrst_rvalid", {28'd0, ArbReq_rvalid}, 32'd0);
        checkVal("midrst_arvalid", {31'd0, ArbBus_arvalid}, 32'd0);
        checkVal("midrst_araddr", {4'd0, ArbBus_araddr}, 32'd0);
        checkVal("midrst_errs", {30'd0, ArbErr_timeout, ArbErr_stray}, 32'd0);
        tick();
        rst_n = 1'b1;
        ReqArb_arvalid = 4'b1111;
        #1;
        checkVal("late_beat_dropped", {28'd0, ArbReq_rvalid}, 32'd0);
        tick();
        BusArb_rvalid = 1'b0;
        checkVal("late_beat_stray", {31'd0, ArbErr_stray}, 32'd1);
        ReqArb_arvalid = 4'd0;
        addrPhase(0, 28'h0000400, 4'd2, 4'd4, 1'b0);
        beat(0, 4'd4, 1'b1, 32'h55);
        checkVal("final_idle", {31'd0, ArbBus_arvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nErrors);
        $finish;
    end

endmodule
